// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the single-cycle core.
// Owns the program counter, holds it through a short boot window after reset,
// then steps it by PC_STEP or redirects it to jump/branch targets. It also
// handles pipeline stalls with a one-entry pending-redirect buffer, and
// halt/resume. All outputs are registered.
module pc_sequencer #(
  parameter logic [31:0] PC_STEP     = 32'd4,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] startPC,
  input  logic        Stall,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Halt,
  input  logic        Resume,
  output logic [31:0] PC,
  output logic        PCValid,
  output logic        Halted,
  output logic        RedirectPending,
  output logic        AlignFault
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_STALLED,
    S_HALTED
  } state_e;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        align_fault_q, align_fault_d;
  logic        pc_valid_q, pc_valid_d;
  logic        halted_q, halted_d;

  logic        live_redirect;
  logic [31:0] live_target_raw;
  logic [31:0] live_target;
  logic        live_misaligned;

  // Select the live redirect request (Jump wins over Branch) and word-align it
  always_comb begin
    live_redirect   = Jump | BranchTaken;
    live_target_raw = Jump ? JumpTarget : BranchTarget;
    live_target     = {live_target_raw[31:2], 2'b00};
    live_misaligned = (live_target_raw[1:0] != 2'b00);
  end

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: halt outranks stall; boot exits after BOOT_CYCLES cycles
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) state_d = S_RUN;
      end
      S_RUN, S_STALLED: begin
        if (Halt)       state_d = S_HALTED;
        else if (Stall) state_d = S_STALLED;
        else            state_d = S_RUN;
      end
      S_HALTED: begin
        if (Resume && !Halt) state_d = S_RUN;
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Datapath: PC update, pending-redirect buffer, boot counter, sticky fault
  always_comb begin
    pc_d          = pc_q;
    boot_cnt_d    = boot_cnt_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    align_fault_d = align_fault_q;
    case (state_q)
      S_BOOT: begin
        boot_cnt_d = boot_cnt_q + 4'd1;
      end
      S_RUN: begin
        if (Halt) begin
          // redirects arriving with Halt are dropped
        end else if (Stall) begin
          if (live_redirect) begin
            pend_valid_d  = 1'b1;
            pend_target_d = live_target;
            align_fault_d = align_fault_q | live_misaligned;
          end
        end else if (live_redirect) begin
          pc_d          = live_target;
          align_fault_d = align_fault_q | live_misaligned;
        end else begin
          pc_d = pc_q + PC_STEP;
        end
      end
      S_STALLED: begin
        if (Halt) begin
          // keep any pending redirect for after resume
        end else if (Stall) begin
          // oldest redirect wins; later ones are ignored while one is held
          if (!pend_valid_q && live_redirect) begin
            pend_valid_d  = 1'b1;
            pend_target_d = live_target;
            align_fault_d = align_fault_q | live_misaligned;
          end
        end else begin
          pend_valid_d = 1'b0;
          if (pend_valid_q) begin
            pc_d = pend_target_q;
          end else if (live_redirect) begin
            pc_d          = live_target;
            align_fault_d = align_fault_q | live_misaligned;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
      end
      S_HALTED: begin
        // resume refetches the held PC unless a redirect was parked
        if (Resume && !Halt && pend_valid_q) begin
          pc_d         = pend_target_q;
          pend_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output decode from the next state so status outputs come straight off flops
  always_comb begin
    pc_valid_d = (state_d == S_RUN) || (state_d == S_STALLED);
    halted_d   = (state_d == S_HALTED);
  end

  // Datapath and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q          <= startPC;
      boot_cnt_q    <= '0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      align_fault_q <= 1'b0;
      pc_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      boot_cnt_q    <= boot_cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      align_fault_q <= align_fault_d;
      pc_valid_q    <= pc_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign PC              = pc_q;
  assign PCValid         = pc_valid_q;
  assign Halted          = halted_q;
  assign RedirectPending = pend_valid_q;
  assign AlignFault      = align_fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a table of one-cycle vectors followed by
// hand-written multi-cycle sequences (stall with pending redirect, halt/resume,
// reset while stalled).
module tb_pc_sequencer;

  logic        Clock;
  logic        Reset;
  logic [31:0] startPC;
  logic        Stall;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Halt;
  logic        Resume;
  logic [31:0] PC;
  logic        PCValid;
  logic        Halted;
  logic        RedirectPending;
  logic        AlignFault;

  int n_vec = 0;
  int n_mis = 0;

  pc_sequencer #(
    .PC_STEP     (32'd4),
    .BOOT_CYCLES (2)
  ) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .startPC         (startPC),
    .Stall           (Stall),
    .Jump            (Jump),
    .JumpTarget      (JumpTarget),
    .BranchTaken     (BranchTaken),
    .BranchTarget    (BranchTarget),
    .Halt            (Halt),
    .Resume          (Resume),
    .PC              (PC),
    .PCValid         (PCValid),
    .Halted          (Halted),
    .RedirectPending (RedirectPending),
    .AlignFault      (AlignFault)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    logic        rst;
    logic [31:0] spc;
    logic        stall;
    logic        jmp;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic        halt;
    logic        res;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_halted;
    logic        e_pend;
    logic        e_fault;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  function automatic vec_t mkv(logic rst, logic [31:0] spc, logic stall,
                               logic jmp, logic [31:0] jt, logic br,
                               logic [31:0] bt, logic halt, logic res,
                               logic [31:0] e_pc, logic e_valid,
                               logic e_halted, logic e_pend, logic e_fault);
    vec_t v;
    v.rst = rst; v.spc = spc; v.stall = stall; v.jmp = jmp; v.jt = jt;
    v.br = br; v.bt = bt; v.halt = halt; v.res = res;
    v.e_pc = e_pc; v.e_valid = e_valid; v.e_halted = e_halted;
    v.e_pend = e_pend; v.e_fault = e_fault;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic stall, input logic jmp,
                       input logic [31:0] jt, input logic br,
                       input logic [31:0] bt, input logic halt,
                       input logic res);
    Reset = rst; Stall = stall; Jump = jmp; JumpTarget = jt;
    BranchTaken = br; BranchTarget = bt; Halt = halt; Resume = res;
  endtask

  // One clock edge, then compare every output against the expectation
  task automatic chk(input string nm, input logic [31:0] e_pc,
                     input logic e_valid, input logic e_halted,
                     input logic e_pend, input logic e_fault);
    @(posedge Clock);
    #1;
    n_vec++;
    if (PC !== e_pc) begin
      n_mis++;
      $display("FAIL %s PC got %h expected %h", nm, PC, e_pc);
    end
    if (PCValid !== e_valid) begin
      n_mis++;
      $display("FAIL %s PCValid got %b expected %b", nm, PCValid, e_valid);
    end
    if (Halted !== e_halted) begin
      n_mis++;
      $display("FAIL %s Halted got %b expected %b", nm, Halted, e_halted);
    end
    if (RedirectPending !== e_pend) begin
      n_mis++;
      $display("FAIL %s RedirectPending got %b expected %b", nm, RedirectPending, e_pend);
    end
    if (AlignFault !== e_fault) begin
      n_mis++;
      $display("FAIL %s AlignFault got %b expected %b", nm, AlignFault, e_fault);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //             rst spc           stl jmp jt        br bt        hlt res  pc            v  h  p  f
    // reset and boot window, then sequential fetch
    vecs[0]  = mkv(1, 32'h00400000, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h00400000, 0, 0, 0, 0);
    vecs[1]  = mkv(0, 32'h00400000, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h00400000, 0, 0, 0, 0);
    vecs[2]  = mkv(0, 32'h00400000, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h00400000, 1, 0, 0, 0);
    vecs[3]  = mkv(0, 32'h00400000, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h00400004, 1, 0, 0, 0);
    vecs[4]  = mkv(0, 32'h00400000, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h00400008, 1, 0, 0, 0);
    // jump beats branch
    vecs[5]  = mkv(0, 32'h00400000, 0, 1, 32'h100,   0, 32'h0,     0, 0, 32'h00000100, 1, 0, 0, 0);
    vecs[6]  = mkv(0, 32'h00400000, 0, 1, 32'h200,   1, 32'h300,   0, 0, 32'h00000200, 1, 0, 0, 0);
    vecs[7]  = mkv(0, 32'h00400000, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h00000204, 1, 0, 0, 0);
    // misaligned target: aligned down, sticky fault
    vecs[8]  = mkv(0, 32'h00400000, 0, 1, 32'h106,   0, 32'h0,     0, 0, 32'h00000104, 1, 0, 0, 1);
    vecs[9]  = mkv(0, 32'h00400000, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h00000108, 1, 0, 0, 1);
    vecs[10] = mkv(0, 32'h00400000, 0, 0, 32'h0,     1, 32'h20,    0, 0, 32'h00000020, 1, 0, 0, 1);
    // reset near top of address space, wrap without flag
    vecs[11] = mkv(1, 32'hFFFFFFF8, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'hFFFFFFF8, 0, 0, 0, 0);
    vecs[12] = mkv(0, 32'hFFFFFFF8, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'hFFFFFFF8, 0, 0, 0, 0);
    vecs[13] = mkv(0, 32'hFFFFFFF8, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'hFFFFFFF8, 1, 0, 0, 0);
    vecs[14] = mkv(0, 32'hFFFFFFF8, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'hFFFFFFFC, 1, 0, 0, 0);
    vecs[15] = mkv(0, 32'hFFFFFFF8, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h00000000, 1, 0, 0, 0);
    vecs[16] = mkv(0, 32'hFFFFFFF8, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h00000004, 1, 0, 0, 0);
    // stall release with live jump; stall with branch parks it
    vecs[17] = mkv(0, 32'hFFFFFFF8, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h00000004, 1, 0, 0, 0);
    vecs[18] = mkv(0, 32'hFFFFFFF8, 0, 1, 32'h50,    0, 32'h0,     0, 0, 32'h00000050, 1, 0, 0, 0);
    vecs[19] = mkv(0, 32'hFFFFFFF8, 1, 0, 32'h0,     1, 32'h60,    0, 0, 32'h00000050, 1, 0, 1, 0);
    vecs[20] = mkv(0, 32'hFFFFFFF8, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h00000060, 1, 0, 0, 0);
    vecs[21] = mkv(0, 32'hFFFFFFF8, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h00000064, 1, 0, 0, 0);

    startPC = 32'h0;
    drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      startPC = vecs[i].spc;
      drive(vecs[i].rst, vecs[i].stall, vecs[i].jmp, vecs[i].jt,
            vecs[i].br, vecs[i].bt, vecs[i].halt, vecs[i].res);
      chk($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid,
          vecs[i].e_halted, vecs[i].e_pend, vecs[i].e_fault);
    end

    // Stall for three cycles; the first redirect (branch) wins over the later jump
    drive(0, 0, 1, 32'h40, 0, 32'h0, 0, 0);
    chk("stall_setup", 32'h40, 1, 0, 0, 0);
    drive(0, 1, 0, 32'h0, 1, 32'h80, 0, 0);
    chk("stall_c1", 32'h40, 1, 0, 1, 0);
    drive(0, 1, 1, 32'h90, 0, 32'h0, 0, 0);
    chk("stall_c2", 32'h40, 1, 0, 1, 0);
    drive(0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
    chk("stall_c3", 32'h40, 1, 0, 1, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    chk("stall_release", 32'h80, 1, 0, 0, 0);
    chk("stall_after", 32'h84, 1, 0, 0, 0);

    // Halt for several cycles, Halt+Resume stays halted, Resume refetches
    drive(0, 0, 1, 32'h20, 0, 32'h0, 0, 0);
    chk("halt_setup", 32'h20, 1, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1, 0);
    chk("halt_enter", 32'h20, 0, 1, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("halt_hold%0d", k), 32'h20, 0, 1, 0, 0);
    end
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1, 1);
    chk("halt_and_resume", 32'h20, 0, 1, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 1);
    chk("resume", 32'h20, 1, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    chk("resume_next", 32'h24, 1, 0, 0, 0);

    // Halt in RUN discards a simultaneous jump
    drive(0, 0, 1, 32'h300, 0, 32'h0, 1, 0);
    chk("halt_drop_jump", 32'h24, 0, 1, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 1);
    chk("halt_drop_resume", 32'h24, 1, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    chk("halt_drop_next", 32'h28, 1, 0, 0, 0);

    // Halt while stalled keeps the pending redirect; Resume takes it
    drive(0, 1, 1, 32'h400, 0, 32'h0, 0, 0);
    chk("stall_park", 32'h28, 1, 0, 1, 0);
    drive(0, 1, 0, 32'h0, 0, 32'h0, 1, 0);
    chk("stall_halt", 32'h28, 0, 1, 1, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 1);
    chk("stall_halt_resume", 32'h400, 1, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    chk("stall_halt_next", 32'h404, 1, 0, 0, 0);

    // Reset while stalled with a pending redirect
    drive(0, 1, 1, 32'h500, 0, 32'h0, 0, 0);
    chk("rst_stall_park", 32'h404, 1, 0, 1, 0);
    startPC = 32'h00001000;
    drive(1, 1, 1, 32'h600, 0, 32'h0, 0, 0);
    chk("rst_stall", 32'h00001000, 0, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    chk("rst_boot", 32'h00001000, 0, 0, 0, 0);
    chk("rst_run", 32'h00001000, 1, 0, 0, 0);
    chk("rst_run_next", 32'h00001004, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
